// File: rtl/ntt_perm_pkg.sv
// Shared constants and types for the 32-lane NTT streaming permutation blocks.
package ntt_perm_pkg;

  localparam int unsigned DATA_WIDTH_PER_INPUT = 28;
  localparam int unsigned INPUT_PER_CYCLE      = 32;
  localparam int unsigned LOG_P                = $clog2(INPUT_PER_CYCLE);
  localparam int unsigned FRAME_BEATS          = INPUT_PER_CYCLE;
  localparam int unsigned PERM_LATENCY         = FRAME_BEATS + 2;
  localparam int unsigned RAM_DEPTH            = 2 * INPUT_PER_CYCLE;
  localparam int unsigned RAM_AW               = LOG_P + 1;

  typedef logic [DATA_WIDTH_PER_INPUT-1:0] lane_word_t;
  typedef logic [LOG_P-1:0]                beat_idx_t;

  typedef struct packed {
    logic              we;
    logic [RAM_AW-1:0] addr;
  } wr_cmd_t;

endpackage

// File: rtl/per_bank_ram.sv
// Simple dual-port bank RAM: one write port, one registered read port.
module per_bank_ram
  import ntt_perm_pkg::*;
(
  input  logic                            clk,
  input  logic                            we,
  input  logic [RAM_AW-1:0]               waddr,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] wdata,
  input  logic                            re,
  input  logic [RAM_AW-1:0]               raddr,
  output logic [DATA_WIDTH_PER_INPUT-1:0] rdata
);

  lane_word_t mem_q [RAM_DEPTH];
  lane_word_t rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/per_dp32_0_inv.sv
// Streaming inverse corner-turn for the 1024-point, 32-lane NTT datapath.
// Ping-pong banked storage with input/output lane rotation so every bank is touched once per beat.
module per_dp32_0_inv
  import ntt_perm_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_start,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_0,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_1,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_2,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_3,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_4,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_5,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_6,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_7,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_8,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_9,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_10,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_11,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_12,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_13,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_14,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_15,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_16,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_17,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_18,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_19,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_20,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_21,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_22,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_23,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_24,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_25,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_26,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_27,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_28,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_29,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_30,
  input  logic [DATA_WIDTH_PER_INPUT-1:0] inData_31,
  output logic                            out_start,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_0,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_1,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_2,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_3,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_4,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_5,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_6,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_7,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_8,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_9,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_10,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_11,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_12,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_13,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_14,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_15,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_16,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_17,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_18,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_19,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_20,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_21,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_22,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_23,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_24,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_25,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_26,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_27,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_28,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_29,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_30,
  output logic [DATA_WIDTH_PER_INPUT-1:0] outData_31
);

  localparam beat_idx_t LAST_BEAT = beat_idx_t'(FRAME_BEATS - 1);

  lane_word_t in_lane   [INPUT_PER_CYCLE];
  lane_word_t rot_d     [INPUT_PER_CYCLE];
  lane_word_t rot_q     [INPUT_PER_CYCLE];
  lane_word_t ram_rdata [INPUT_PER_CYCLE];
  lane_word_t out_d     [INPUT_PER_CYCLE];
  lane_word_t out_q     [INPUT_PER_CYCLE];
  logic [RAM_AW-1:0] raddr_c [INPUT_PER_CYCLE];

  logic      wr_active_d, wr_active_q;
  beat_idx_t wcnt_d, wcnt_q;
  logic      wbuf_d, wbuf_q;
  logic      wr_done_d, wr_done_q;
  logic      wr_done_buf_d, wr_done_buf_q;
  wr_cmd_t   wcmd_d, wcmd_q;
  logic      rd_active_d, rd_active_q;
  beat_idx_t rcnt_d, rcnt_q;
  logic      rbuf_d, rbuf_q;
  logic      rd_v1_d, rd_v1_q;
  beat_idx_t r1_d, r1_q;
  logic      out_start_d, out_start_q;
  logic      beat_en;
  beat_idx_t beat_idx;

  assign in_lane[0]  = inData_0;
  assign in_lane[1]  = inData_1;
  assign in_lane[2]  = inData_2;
  assign in_lane[3]  = inData_3;
  assign in_lane[4]  = inData_4;
  assign in_lane[5]  = inData_5;
  assign in_lane[6]  = inData_6;
  assign in_lane[7]  = inData_7;
  assign in_lane[8]  = inData_8;
  assign in_lane[9]  = inData_9;
  assign in_lane[10] = inData_10;
  assign in_lane[11] = inData_11;
  assign in_lane[12] = inData_12;
  assign in_lane[13] = inData_13;
  assign in_lane[14] = inData_14;
  assign in_lane[15] = inData_15;
  assign in_lane[16] = inData_16;
  assign in_lane[17] = inData_17;
  assign in_lane[18] = inData_18;
  assign in_lane[19] = inData_19;
  assign in_lane[20] = inData_20;
  assign in_lane[21] = inData_21;
  assign in_lane[22] = inData_22;
  assign in_lane[23] = inData_23;
  assign in_lane[24] = inData_24;
  assign in_lane[25] = inData_25;
  assign in_lane[26] = inData_26;
  assign in_lane[27] = inData_27;
  assign in_lane[28] = inData_28;
  assign in_lane[29] = inData_29;
  assign in_lane[30] = inData_30;
  assign in_lane[31] = inData_31;

  // Write framing: in_start only opens a frame when none is in progress.
  always_comb begin
    wr_active_d   = wr_active_q;
    wcnt_d        = wcnt_q;
    wbuf_d        = wbuf_q;
    wr_done_d     = 1'b0;
    wr_done_buf_d = wr_done_buf_q;
    beat_en       = wr_active_q | in_start;
    beat_idx      = wr_active_q ? wcnt_q : '0;
    if (beat_en) begin
      if (beat_idx == LAST_BEAT) begin
        wr_active_d   = 1'b0;
        wcnt_d        = '0;
        wbuf_d        = ~wbuf_q;
        wr_done_d     = 1'b1;
        wr_done_buf_d = wbuf_q;
      end else begin
        wr_active_d = 1'b1;
        wcnt_d      = beat_idx + 1'b1;
      end
    end
  end

  // Input rotation: lane j of beat t lands in bank (j+t) mod P.
  always_comb begin
    wcmd_d.we   = beat_en;
    wcmd_d.addr = {wbuf_q, beat_idx};
    for (int b = 0; b < INPUT_PER_CYCLE; b++) begin
      rot_d[b] = beat_en ? in_lane[beat_idx_t'(beat_idx_t'(b) - beat_idx)] : rot_q[b];
    end
  end

  // Read sequencing; a completed write frame restarts the read with no bubble.
  always_comb begin
    rd_active_d = rd_active_q;
    rcnt_d      = rcnt_q;
    rbuf_d      = rbuf_q;
    rd_v1_d     = rd_active_q;
    r1_d        = rcnt_q;
    if (wr_done_q) begin
      rd_active_d = 1'b1;
      rcnt_d      = '0;
      rbuf_d      = wr_done_buf_q;
    end else if (rd_active_q) begin
      if (rcnt_q == LAST_BEAT) rd_active_d = 1'b0;
      else                     rcnt_d      = rcnt_q + 1'b1;
    end
    for (int b = 0; b < INPUT_PER_CYCLE; b++) begin
      raddr_c[b] = {rbuf_q, beat_idx_t'(beat_idx_t'(b) - rcnt_q)};
    end
  end

  // Output rotation back to lane order; outputs hold between frames.
  always_comb begin
    out_start_d = 1'b0;
    for (int j = 0; j < INPUT_PER_CYCLE; j++) begin
      out_d[j] = out_q[j];
    end
    if (rd_v1_q) begin
      out_start_d = (r1_q == '0);
      for (int j = 0; j < INPUT_PER_CYCLE; j++) begin
        out_d[j] = ram_rdata[beat_idx_t'(r1_q + beat_idx_t'(j))];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_active_q   <= 1'b0;
      wcnt_q        <= '0;
      wbuf_q        <= 1'b0;
      wr_done_q     <= 1'b0;
      wr_done_buf_q <= 1'b0;
      wcmd_q        <= '0;
      rd_active_q   <= 1'b0;
      rcnt_q        <= '0;
      rbuf_q        <= 1'b0;
      rd_v1_q       <= 1'b0;
      r1_q          <= '0;
      out_start_q   <= 1'b0;
      for (int j = 0; j < INPUT_PER_CYCLE; j++) out_q[j] <= '0;
    end else begin
      wr_active_q   <= wr_active_d;
      wcnt_q        <= wcnt_d;
      wbuf_q        <= wbuf_d;
      wr_done_q     <= wr_done_d;
      wr_done_buf_q <= wr_done_buf_d;
      wcmd_q        <= wcmd_d;
      rd_active_q   <= rd_active_d;
      rcnt_q        <= rcnt_d;
      rbuf_q        <= rbuf_d;
      rd_v1_q       <= rd_v1_d;
      r1_q          <= r1_d;
      out_start_q   <= out_start_d;
      for (int j = 0; j < INPUT_PER_CYCLE; j++) out_q[j] <= out_d[j];
    end
  end

  // Rotated write data needs no reset; it is qualified by wcmd_q.we.
  always_ff @(posedge clk) begin
    for (int b = 0; b < INPUT_PER_CYCLE; b++) rot_q[b] <= rot_d[b];
  end

  for (genvar b = 0; b < INPUT_PER_CYCLE; b++) begin : g_bank
    per_bank_ram u_ram (
      .clk   (clk),
      .we    (wcmd_q.we),
      .waddr (wcmd_q.addr),
      .wdata (rot_q[b]),
      .re    (rd_active_q),
      .raddr (raddr_c[b]),
      .rdata (ram_rdata[b])
    );
  end

  assign out_start = out_start_q;
  assign outData_0  = out_q[0];
  assign outData_1  = out_q[1];
  assign outData_2  = out_q[2];
  assign outData_3  = out_q[3];
  assign outData_4  = out_q[4];
  assign outData_5  = out_q[5];
  assign outData_6  = out_q[6];
  assign outData_7  = out_q[7];
  assign outData_8  = out_q[8];
  assign outData_9  = out_q[9];
  assign outData_10 = out_q[10];
  assign outData_11 = out_q[11];
  assign outData_12 = out_q[12];
  assign outData_13 = out_q[13];
  assign outData_14 = out_q[14];
  assign outData_15 = out_q[15];
  assign outData_16 = out_q[16];
  assign outData_17 = out_q[17];
  assign outData_18 = out_q[18];
  assign outData_19 = out_q[19];
  assign outData_20 = out_q[20];
  assign outData_21 = out_q[21];
  assign outData_22 = out_q[22];
  assign outData_23 = out_q[23];
  assign outData_24 = out_q[24];
  assign outData_25 = out_q[25];
  assign outData_26 = out_q[26];
  assign outData_27 = out_q[27];
  assign outData_28 = out_q[28];
  assign outData_29 = out_q[29];
  assign outData_30 = out_q[30];
  assign outData_31 = out_q[31];

endmodule
